// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and constants for the reset sequencer
// Contents: FSM state enum, reset-cause encodings, small max helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_IDLE    = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_req_sync.sv
// rtl/reset_req_sync.sv - two-flop synchronizer for the external reset request
// Ports: clk, rst (sync, active-high, clears both flops), d_i (async level),
//        q_o (d_i delayed by two clk edges, safe to use in the clk domain).
module reset_req_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered reset release sequencer
// Ports: clk, rst (sync, active-high), req_async (async external request),
//        sw_req (clk-synchronous software request), rst_out[N_OUT] (ordered
//        resets, bit 0 released first), busy (not idle), done (pulse on last
//        release), cause (last reset cause). All outputs are registered.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_OUT       = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_async,
  input  logic             sw_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       cause
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0] ALL_ONES  = {N_OUT{1'b1}};
  localparam logic [N_OUT-1:0] BIT0      = N_OUT'(1);

  logic req_sync;
  logic req;
  logic [1:0] req_cause;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] rst_out_q, rst_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;

  reset_req_sync u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (req_async),
    .q_o (req_sync)
  );

  assign req       = req_sync | sw_req;
  assign req_cause = req_sync ? CAUSE_EXT : CAUSE_SW;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= HOLD_LOAD;
      idx_q     <= '0;
      rst_out_q <= ALL_ONES;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      cause_q   <= CAUSE_POR;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = 1'b0;
    cause_d   = cause_q;

    if (req && (state_q != ST_ASSERT)) begin
      // Fresh entry into ASSERT from any other state restarts the sequence.
      state_d   = ST_ASSERT;
      rst_out_d = ALL_ONES;
      cnt_d     = HOLD_LOAD;
      idx_d     = '0;
      cause_d   = req_cause;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          rst_out_d = ALL_ONES;
          if (req) begin
            // A request while holding only stretches the hold window.
            cnt_d = HOLD_LOAD;
          end else if (cnt_q == '0) begin
            // Bit 0 clears on the same edge RELEASE is entered.
            rst_out_d = ALL_ONES & ~BIT0;
            if (N_OUT == 1) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = GAP_LOAD;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          // idx_q names the next bit to clear; lower bits are already low.
          if (cnt_q == '0) begin
            rst_out_d = rst_out_q & ~(BIT0 << idx_q);
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = GAP_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          rst_out_d = '0;
          state_d   = ST_IDLE;
        end
        ST_IDLE: begin
          rst_out_d = '0;
        end
        default: begin
          state_d = ST_ASSERT;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cause   = cause_q;

endmodule
